// File: rtl/mips_bus_pkg.sv
// Shared types and constants for the mips_cpu_bus memory-side arbiter.
package mips_bus_pkg;
  typedef enum logic [1:0] {IDLE, GRANT0, GRANT1} arb_state_t;
  localparam logic [31:0] ABORT_DATA_DEFAULT = 32'hDEADBEEF;
endpackage

// File: rtl/mips_bus_watchdog.sv
// Saturating-free wait counter: cleared explicitly, flags TIMEOUT-1 reached.
module mips_bus_watchdog #(
  parameter int TIMEOUT = 1024
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic count_en,
  output logic expired
);
  localparam int CW = $clog2(TIMEOUT) + 1;

  logic [CW-1:0] wait_cnt_q, wait_cnt_d;

  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (clear) begin
      wait_cnt_d = '0;
    end else if (count_en) begin
      wait_cnt_d = wait_cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wait_cnt_q <= '0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
    end
  end

  assign expired = (wait_cnt_q == CW'(TIMEOUT - 1));
endmodule

// File: rtl/mips_avalon_arbiter.sv
// Two-master round-robin Avalon-MM arbiter with a stuck-slave watchdog.
module mips_avalon_arbiter
  import mips_bus_pkg::*;
#(
  parameter int          ADDR_W     = 32,
  parameter int          TIMEOUT    = 1024,
  parameter logic [31:0] ABORT_DATA = ABORT_DATA_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] m0_address,
  input  logic              m0_read,
  input  logic              m0_write,
  input  logic [31:0]       m0_writedata,
  input  logic [3:0]        m0_byteenable,
  output logic              m0_waitrequest,
  output logic [31:0]       m0_readdata,
  input  logic [ADDR_W-1:0] m1_address,
  input  logic              m1_read,
  input  logic              m1_write,
  input  logic [31:0]       m1_writedata,
  input  logic [3:0]        m1_byteenable,
  output logic              m1_waitrequest,
  output logic [31:0]       m1_readdata,
  output logic [ADDR_W-1:0] s_address,
  output logic              s_read,
  output logic              s_write,
  output logic [31:0]       s_writedata,
  output logic [3:0]        s_byteenable,
  input  logic              s_waitrequest,
  input  logic [31:0]       s_readdata,
  output logic [1:0]        grant,
  output logic              bus_error
);
  arb_state_t state_q, state_d;
  logic last_q, last_d;
  logic err_q, err_d;
  logic clear, count_en, expired, abort;
  logic req0, req1, own, req_own;

  assign req0    = m0_read | m0_write;
  assign req1    = m1_read | m1_write;
  assign own     = (state_q == GRANT1);
  assign req_own = own ? req1 : req0;

  mips_bus_watchdog #(.TIMEOUT(TIMEOUT)) u_wdog (
    .clk      (clk),
    .reset    (reset),
    .clear    (clear),
    .count_en (count_en),
    .expired  (expired)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    last_d   = last_q;
    err_d    = err_q;
    clear    = 1'b0;
    count_en = 1'b0;
    abort    = 1'b0;
    unique case (state_q)
      IDLE: begin
        clear = 1'b1;
        if (req0 && (!req1 || last_q)) begin
          state_d = GRANT0;
        end else if (req1) begin
          state_d = GRANT1;
        end
      end
      GRANT0, GRANT1: begin
        // a dropped request is abandoned without updating fairness
        if (!req_own) begin
          state_d = IDLE;
          clear   = 1'b1;
        end else if (!s_waitrequest) begin
          state_d = IDLE;
          last_d  = own;
          clear   = 1'b1;
        end else if (expired) begin
          abort   = 1'b1;
          state_d = IDLE;
          last_d  = own;
          err_d   = 1'b1;
          clear   = 1'b1;
        end else begin
          count_en = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    s_address      = '0;
    s_read         = 1'b0;
    s_write        = 1'b0;
    s_writedata    = '0;
    s_byteenable   = '0;
    m0_waitrequest = 1'b1;
    m1_waitrequest = 1'b1;
    m0_readdata    = '0;
    m1_readdata    = '0;
    grant          = 2'b00;
    if (!reset) begin
      unique case (state_q)
        GRANT0: begin
          s_address      = m0_address;
          s_read         = m0_read & ~abort;
          s_write        = m0_write & ~abort;
          s_writedata    = m0_writedata;
          s_byteenable   = m0_byteenable;
          m0_waitrequest = s_waitrequest & ~abort;
          m0_readdata    = abort ? ABORT_DATA : s_readdata;
          grant          = 2'b01;
        end
        GRANT1: begin
          s_address      = m1_address;
          s_read         = m1_read & ~abort;
          s_write        = m1_write & ~abort;
          s_writedata    = m1_writedata;
          s_byteenable   = m1_byteenable;
          m1_waitrequest = s_waitrequest & ~abort;
          m1_readdata    = abort ? ABORT_DATA : s_readdata;
          grant          = 2'b10;
        end
        default: ;
      endcase
    end
  end

  assign bus_error = err_q;
endmodule

// File: tb/tb_mips_avalon_arbiter.sv
// Directed bench for mips_avalon_arbiter with a completion scoreboard.
module tb_mips_avalon_arbiter;
  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] m0_address, m1_address, s_address;
  logic        m0_read, m0_write, m1_read, m1_write;
  logic [31:0] m0_writedata, m1_writedata, s_writedata;
  logic [3:0]  m0_byteenable, m1_byteenable, s_byteenable;
  logic        m0_waitrequest, m1_waitrequest;
  logic [31:0] m0_readdata, m1_readdata;
  logic        s_read, s_write, s_waitrequest;
  logic [31:0] s_readdata;
  logic [1:0]  grant;
  logic        bus_error;

  logic        hang = 1'b0;
  int          stall_cfg = 0;
  int          act_cnt = 0;
  logic [31:0] rd_cfg = '0;

  int errors = 0;
  int checks = 0;

  typedef struct {
    int          mst;
    logic [31:0] addr;
    logic        wr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] rdata;
    logic        abrt;
  } exp_t;
  exp_t sbq[$];
  exp_t e;

  mips_avalon_arbiter #(
    .ADDR_W(32), .TIMEOUT(8), .ABORT_DATA(32'hDEADBEEF)
  ) dut (
    .clk(clk), .reset(reset),
    .m0_address(m0_address), .m0_read(m0_read), .m0_write(m0_write),
    .m0_writedata(m0_writedata), .m0_byteenable(m0_byteenable),
    .m0_waitrequest(m0_waitrequest), .m0_readdata(m0_readdata),
    .m1_address(m1_address), .m1_read(m1_read), .m1_write(m1_write),
    .m1_writedata(m1_writedata), .m1_byteenable(m1_byteenable),
    .m1_waitrequest(m1_waitrequest), .m1_readdata(m1_readdata),
    .s_address(s_address), .s_read(s_read), .s_write(s_write),
    .s_writedata(s_writedata), .s_byteenable(s_byteenable),
    .s_waitrequest(s_waitrequest), .s_readdata(s_readdata),
    .grant(grant), .bus_error(bus_error)
  );

  always #5 clk = ~clk;

  // slave: stalls stall_cfg cycles per transfer, or forever while hang
  assign s_waitrequest = hang || (grant != 2'b00 && act_cnt < stall_cfg);
  assign s_readdata    = rd_cfg;
  always @(posedge clk) begin
    if (grant != 2'b00 && s_waitrequest) act_cnt <= act_cnt + 1;
    else act_cnt <= 0;
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic exp_t mk(input int m, input logic [31:0] a,
                              input logic w, input logic [31:0] d,
                              input logic [3:0] b, input logic [31:0] r,
                              input logic ab);
    exp_t x;
    x.mst = m; x.addr = a; x.wr = w; x.wdata = d;
    x.be = b; x.rdata = r; x.abrt = ab;
    return x;
  endfunction

  always @(negedge clk) begin
    if (!reset && (!m0_waitrequest || !m1_waitrequest)) begin
      if (sbq.size() == 0) begin
        chk("unexpected_done", 32'({m0_waitrequest, m1_waitrequest}), 32'h3);
      end else begin
        e = sbq.pop_front();
        chk("done_mst", m0_waitrequest ? 32'd1 : 32'd0, 32'(e.mst));
        chk("grant", 32'(grant), e.mst == 1 ? 32'h2 : 32'h1);
        chk("s_address", s_address, e.addr);
        chk("other_wait", 32'(e.mst == 1 ? m0_waitrequest : m1_waitrequest), 32'h1);
        chk("other_rdata", e.mst == 1 ? m0_readdata : m1_readdata, 32'h0);
        if (e.abrt) begin
          chk("abort_rw", 32'({s_read, s_write}), 32'h0);
        end else begin
          chk("rw", 32'({s_read, s_write}), e.wr ? 32'h1 : 32'h2);
        end
        if (!e.wr) chk("rdata", e.mst == 1 ? m1_readdata : m0_readdata, e.rdata);
        if (e.wr) begin
          chk("wdata", s_writedata, e.wdata);
          chk("be", 32'(s_byteenable), 32'(e.be));
        end
      end
    end
  end

  task automatic mreq(input int m, input logic wr, input logic [31:0] a,
                      input logic [31:0] d, input logic [3:0] b);
    int   n = 0;
    logic done = 1'b0;
    if (m == 0) begin
      m0_address = a; m0_read = !wr; m0_write = wr;
      m0_writedata = d; m0_byteenable = b;
    end else begin
      m1_address = a; m1_read = !wr; m1_write = wr;
      m1_writedata = d; m1_byteenable = b;
    end
    while (!done && n < 60) begin
      @(negedge clk);
      n++;
      if ((m == 0 ? m0_waitrequest : m1_waitrequest) == 1'b0) done = 1'b1;
    end
    chk("req_timeout", 32'(done), 32'h1);
    @(posedge clk);
    #1;
    if (m == 0) begin
      m0_read = 1'b0; m0_write = 1'b0;
    end else begin
      m1_read = 1'b0; m1_write = 1'b0;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got stuck expected finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    int k;
    m0_address = '0; m0_read = 0; m0_write = 0; m0_writedata = '0; m0_byteenable = '0;
    m1_address = '0; m1_read = 0; m1_write = 0; m1_writedata = '0; m1_byteenable = '0;
    reset = 1'b1;
    @(negedge clk);
    chk("rst_grant", 32'(grant), 32'h0);
    chk("rst_wait", 32'({m0_waitrequest, m1_waitrequest}), 32'h3);
    chk("rst_rw", 32'({s_read, s_write}), 32'h0);
    chk("rst_err", 32'(bus_error), 32'h0);
    do_reset();

    // single m0 read, zero-wait slave
    rd_cfg = 32'h12345678;
    sbq.push_back(mk(0, 32'h1000, 0, 0, 0, 32'h12345678, 0));
    m0_address = 32'h1000; m0_read = 1'b1; m0_byteenable = 4'hF;
    @(negedge clk);
    chk("t1_c1_grant", 32'(grant), 32'h0);
    chk("t1_c1_m1w", 32'(m1_waitrequest), 32'h1);
    @(negedge clk);
    chk("t1_c2_grant", 32'(grant), 32'h1);
    chk("t1_c2_m0w", 32'(m0_waitrequest), 32'h0);
    chk("t1_c2_m1w", 32'(m1_waitrequest), 32'h1);
    @(posedge clk);
    #1 m0_read = 1'b0;
    @(negedge clk);
    chk("t1_c3_grant", 32'(grant), 32'h0);

    // simultaneous pairs from reset alternate m0, m1, m0, m1
    do_reset();
    rd_cfg = 32'h0000_0A0A;
    sbq.push_back(mk(0, 32'h0100, 0, 0, 0, 32'h0000_0A0A, 0));
    sbq.push_back(mk(1, 32'h0200, 0, 0, 0, 32'h0000_0A0A, 0));
    fork
      mreq(0, 0, 32'h0100, 0, 4'hF);
      mreq(1, 0, 32'h0200, 0, 4'hF);
    join
    sbq.push_back(mk(0, 32'h0300, 1, 32'h11, 4'h1, 0, 0));
    sbq.push_back(mk(1, 32'h0400, 1, 32'h22, 4'h2, 0, 0));
    fork
      mreq(0, 1, 32'h0300, 32'h11, 4'h1);
      mreq(1, 1, 32'h0400, 32'h22, 4'h2);
    join

    // m1 write with a 3-cycle slave stall
    stall_cfg = 3;
    sbq.push_back(mk(1, 32'h2000, 1, 32'hAABBCCDD, 4'b0011, 0, 0));
    fork
      mreq(1, 1, 32'h2000, 32'hAABBCCDD, 4'b0011);
      begin
        k = 0;
        for (int i = 0; i < 20; i++) begin
          @(negedge clk);
          if (grant == 2'b10) begin
            k++;
            chk("t3_addr", s_address, 32'h2000);
            chk("t3_wdata", s_writedata, 32'hAABBCCDD);
            chk("t3_be", 32'(s_byteenable), 32'h3);
            chk("t3_wr", 32'({s_read, s_write}), 32'h1);
            chk("t3_m1w", 32'(m1_waitrequest), k < 4 ? 32'h1 : 32'h0);
          end
        end
        chk("t3_cycles", 32'(k), 32'd4);
      end
    join
    stall_cfg = 0;

    // hung slave: watchdog aborts on the 8th granted cycle
    hang = 1'b1;
    sbq.push_back(mk(0, 32'h3000, 0, 0, 0, 32'hDEADBEEF, 1));
    fork
      mreq(0, 0, 32'h3000, 0, 4'hF);
      begin
        k = 0;
        for (int i = 0; i < 20; i++) begin
          @(negedge clk);
          if (grant == 2'b01) begin
            k++;
            chk("t4_m0w", 32'(m0_waitrequest), k == 8 ? 32'h0 : 32'h1);
            chk("t4_err_pre", 32'(bus_error), 32'h0);
          end
        end
        chk("t4_cycles", 32'(k), 32'd8);
        chk("t4_err_post", 32'(bus_error), 32'h1);
      end
    join
    hang = 1'b0;
    rd_cfg = 32'h5555_0001;
    sbq.push_back(mk(1, 32'h5000, 0, 0, 0, 32'h5555_0001, 0));
    mreq(1, 0, 32'h5000, 0, 4'hF);
    chk("t4_err_sticky", 32'(bus_error), 32'h1);

    // reset in the 2nd cycle of a stalled m1 transfer
    hang = 1'b1;
    m1_address = 32'h4000; m1_read = 1'b1;
    @(negedge clk);
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("t5_sread_pre", 32'(s_read), 32'h1);
    reset = 1'b1;
    #1;
    chk("t5_sread_rst", 32'(s_read), 32'h0);
    chk("t5_m1w_rst", 32'(m1_waitrequest), 32'h1);
    @(posedge clk);
    #1 reset = 1'b0;
    m1_read = 1'b0; hang = 1'b0;
    @(negedge clk);
    chk("t5_grant", 32'(grant), 32'h0);
    chk("t5_err", 32'(bus_error), 32'h0);
    rd_cfg = 32'h7777_0000;
    sbq.push_back(mk(0, 32'h6000, 0, 0, 0, 32'h7777_0000, 0));
    sbq.push_back(mk(1, 32'h7000, 0, 0, 0, 32'h7777_0000, 0));
    @(posedge clk);
    #1;
    fork
      mreq(0, 0, 32'h6000, 0, 4'hF);
      mreq(1, 0, 32'h7000, 0, 4'hF);
    join

    for (int i = 0; i < 10 && sbq.size() != 0; i++) @(negedge clk);
    chk("sb_left", 32'(sbq.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
